// File: rtl/johnson_seq_pkg.sv
// -----------------------------------------------------------------------------
// johnson_seq_pkg
// Shared types and constants for the Johnson phase sequencer:
//   state_t  - controller FSM states (IDLE, RUN, DONE)
//   DIR_FWD  - step direction value for forward motion
//   DIR_REV  - step direction value for reverse motion
// -----------------------------------------------------------------------------
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_ring_bidir.sv
// -----------------------------------------------------------------------------
// johnson_ring_bidir
// N-stage Johnson ring that moves one state per enabled cycle, forward or
// reverse, and tracks its index (0..2N-1) in the forward sequence that
// starts from all-zeros.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (ring and index to 0)
//   step_en  in   take one step on this edge
//   dir      in   0 = forward, 1 = reverse
//   phase    out  ring state, N bits (registered)
//   pos      out  ring index, POS_W bits (registered)
// -----------------------------------------------------------------------------
module johnson_ring_bidir
    import johnson_seq_pkg::*;
#(
    parameter  int N     = 4,
    localparam int POS_W = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             dir,
    output logic [N-1:0]     phase,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * N - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            pos   <= '0;
        end else if (step_en) begin
            if (dir == DIR_FWD) begin
                // Shift toward the LSB, feeding the inverted LSB into the MSB.
                phase <= {~phase[0], phase[N-1:1]};
                pos   <= (pos == POS_LAST) ? '0 : pos + 1'b1;
            end else begin
                // Exact inverse of the forward move.
                phase <= {phase[N-2:0], ~phase[N-1]};
                pos   <= (pos == '0) ? POS_LAST : pos - 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
// Command-driven phase sequencer. A command (steps, direction, rate divider)
// is accepted in IDLE; the Johnson ring is then stepped once every div+1
// cycles until the step count is exhausted or abort is raised. Ring position
// persists between commands.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  high in IDLE (combinational from state)
//   cmd_steps  in   number of steps, STEP_W bits
//   cmd_dir    in   0 = forward, 1 = reverse
//   cmd_div    in   step period minus one in clk cycles, DIV_W bits
//   abort      in   stop the running command (ignored outside RUN)
//   phase      out  Johnson ring state, N bits
//   pos        out  ring index 0..2N-1, POS_W bits
//   busy       out  high while running
//   done       out  one-cycle completion pulse
//   aborted    out  qualifies done: command ended by abort
// -----------------------------------------------------------------------------
module johnson_seq_ctrl
    import johnson_seq_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int STEP_W = 16,
    parameter  int DIV_W  = 8,
    localparam int POS_W  = $clog2(2 * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              abort,
    output logic [N-1:0]      phase,
    output logic [POS_W-1:0]  pos,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    state_t              state;
    logic                dir_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt;
    logic [STEP_W-1:0]   remaining;
    logic                step_en;

    assign cmd_ready = (state == IDLE);

    // Abort wins over a due step, so an aborted cycle never moves the ring.
    assign step_en = (state == RUN) && !abort && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= DIR_FWD;
            div_q     <= '0;
            cnt       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        dir_q     <= cmd_dir;
                        div_q     <= cmd_div;
                        cnt       <= cmd_div;
                        remaining <= cmd_steps;
                        aborted   <= 1'b0;
                        if (cmd_steps == '0) begin
                            // Nothing to do: report completion straight away.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt == '0) begin
                        // The ring steps on this edge via step_en.
                        cnt       <= div_q;
                        remaining <= remaining - 1'b1;
                        if (remaining == STEP_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    johnson_ring_bidir #(
        .N (N)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .dir     (dir_q),
        .phase   (phase),
        .pos     (pos)
    );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [7:0]  cmd_div;
    logic        abort;
    logic [3:0]  phase;
    logic [2:0]  pos;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] steps;
        logic        dir;
        logic [7:0]  div;
        logic [3:0]  ph;
        logic [2:0]  ps;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t vecs[7];

    johnson_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_div   (cmd_div),
        .abort     (abort),
        .phase     (phase),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Present a command for one accepting edge, then drop cmd_valid.
    task automatic issue(input logic [15:0] s, input logic d, input logic [7:0] v);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_steps = s;
        cmd_dir   = d;
        cmd_div   = v;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // k = edges after the accepting edge until done is visible.
    task automatic wait_done(output int k, output int bsy, output bit ok);
        k = 0;
        bsy = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   b;
        bit   ok;
        string nm;
        logic [3:0] t1_ph[4];

        t1_ph = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};

        //          steps  dir   div   phase    pos   lat bsy
        vecs[0] = '{16'd3, 1'b1, 8'd0, 4'b0000, 3'd0, 3, 3};
        vecs[1] = '{16'd9, 1'b0, 8'd0, 4'b1000, 3'd1, 9, 9};
        vecs[2] = '{16'd1, 1'b1, 8'd0, 4'b0000, 3'd0, 1, 1};
        vecs[3] = '{16'd1, 1'b1, 8'd2, 4'b0001, 3'd7, 3, 3};
        vecs[4] = '{16'd0, 1'b0, 8'd5, 4'b0001, 3'd7, 0, 0};
        vecs[5] = '{16'd2, 1'b0, 8'd3, 4'b1000, 3'd1, 8, 8};
        vecs[6] = '{16'd5, 1'b1, 8'd0, 4'b1111, 3'd4, 5, 5};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        cmd_dir = 1'b0;
        cmd_div = '0;
        abort = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b0;

        // Forward 3 at full rate: one ring step per edge after acceptance.
        issue(16'd3, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t1_phase_k%0d", i), phase, t1_ph[i]);
            chk($sformatf("t1_done_k%0d", i), done, (i == 3));
        end
        chk("t1_pos", pos, 3);
        chk("t1_busy_at_done", busy, 0);
        @(negedge clk);
        chk("t1_ready_after", cmd_ready, 1);
        chk("t1_done_cleared", done, 0);

        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].steps, vecs[v].dir, vecs[v].div);
            wait_done(k, b, ok);
            nm = $sformatf("v%0d", v);
            chk({nm, "_done_seen"}, ok, 1);
            if (ok) begin
                chk({nm, "_phase"}, phase, vecs[v].ph);
                chk({nm, "_pos"}, pos, vecs[v].ps);
                chk({nm, "_latency"}, k, vecs[v].lat);
                chk({nm, "_busy_cycles"}, b, vecs[v].bsy);
                chk({nm, "_aborted"}, aborted, 0);
            end
            @(negedge clk);
            chk({nm, "_done_pulse_len"}, done, 0);
            chk({nm, "_ready_after"}, cmd_ready, 1);
        end

        // Reset mid-run at pos 5 with a new command already waiting.
        issue(16'd100, 1'b0, 8'd0);
        @(negedge clk);
        chk("rr_k0_pos", pos, 4);
        chk("rr_k0_busy", busy, 1);
        @(negedge clk);
        chk("rr_k1_pos", pos, 5);
        chk("rr_k1_phase", phase, 4'b0111);
        cmd_steps = 16'd2;
        cmd_dir = 1'b0;
        cmd_div = 8'd0;
        cmd_valid = 1'b1;
        chk("rr_ready_in_run", cmd_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_phase", phase, 0);
        chk("rr_pos", pos, 0);
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(k, b, ok);
        chk("rr2_done_seen", ok, 1);
        chk("rr2_latency", k, 2);
        chk("rr2_pos", pos, 2);
        chk("rr2_phase", phase, 4'b1100);

        // Abort a slow forward run just as a step is due (pos 2 -> 4, then stop).
        issue(16'd100, 1'b0, 8'd1);
        repeat (6) @(negedge clk);
        chk("ab_pos_before", pos, 4);
        chk("ab_busy_before", busy, 1);
        chk("ab_done_before", done, 0);
        abort = 1'b1;
        cmd_steps = 16'd1;
        cmd_dir = 1'b1;
        cmd_div = 8'd0;
        cmd_valid = 1'b1;
        chk("ab_ready_in_run", cmd_ready, 0);
        @(negedge clk);
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_pos_no_step", pos, 4);
        chk("ab_phase_no_step", phase, 4'b1111);
        chk("ab_busy", busy, 0);
        @(negedge clk);
        chk("ab_idle_done", done, 0);
        chk("ab_idle_ready", cmd_ready, 1);
        chk("ab_idle_aborted_held", aborted, 1);
        // Held command is accepted here; abort is still high but must be ignored in IDLE.
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("ab2_busy", busy, 1);
        chk("ab2_aborted_cleared", aborted, 0);
        @(negedge clk);
        chk("ab2_done", done, 1);
        chk("ab2_aborted", aborted, 0);
        chk("ab2_pos", pos, 3);
        chk("ab2_phase", phase, 4'b1110);
        @(negedge clk);
        chk("ab2_ready_after", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
